stack_sequencer: RTL and testbench

Command-level controller for the 128-entry, 16-bit register stack. It accepts one stack command at a time from the instruction decoder over a valid/ready handshake. It drives the stack's push/pop/write/read strobes and data inputs, and keeps the authoritative depth count with overflow/underflow protection. It returns the resulting top-of-stack to the requester over a separate valid/ready response channel.

---
 rtl/stack_pkg.sv | 46 ++++
 rtl/stack_sequencer_if.sv | 31 +++
 rtl/stack_depth_tracker.sv | 64 ++++++
 rtl/stack_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the stack command sequencer:
//   - size defaults (DEPTH entries of DW bits, DEPTH_W-bit depth count)
//   - command opcodes carried on cmd_op
//   - response error codes carried on rsp_err
//   - sequencer FSM state encoding
//   - opcode classification helpers (grows / shrinks the stack)
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam int DEPTH   = 128;
    localparam int DW      = 16;
    localparam int DEPTH_W = 8;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_DROP = 3'd4;
    localparam logic [2:0] OP_SWAP = 3'd5;
    localparam logic [2:0] OP_OVER = 3'd6;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_OVF = 2'd1;
    localparam logic [1:0] ERR_UNF = 2'd2;
    localparam logic [1:0] ERR_ILL = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    // Commands that add one entry to the stack.
    function automatic logic is_grow(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
    endfunction

    // Commands that remove one entry from the stack.
    function automatic logic is_shrink(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_DROP);
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// -----------------------------------------------------------------------------
// stack_sequencer_if
// Command and response channels between the instruction decoder and the
// stack sequencer.
//   cmd_valid/cmd_ready/cmd_op/cmd_data : one stack command per handshake
//   rsp_valid/rsp_ready/rsp_data/rsp_err: resulting top of stack + error code
// Modports: master = decoder side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface stack_sequencer_if;
    import stack_pkg::*;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/stack_depth_tracker.sv
// -----------------------------------------------------------------------------
// stack_depth_tracker
// Authoritative entry count of the register stack plus the legality check.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   op          : opcode to be checked against the current depth
//   inc, dec    : move depth by one (never both; only for legal commands)
//   depth       : current entry count, 0..DEPTH
//   full, empty : depth == DEPTH, depth == 0
//   err         : error code the op would produce at the current depth
// Depth never wraps because inc/dec are only issued for commands that passed
// the legality check; no saturation logic is needed here.
// -----------------------------------------------------------------------------
module stack_depth_tracker #(
    parameter int DEPTH   = stack_pkg::DEPTH,
    parameter int DEPTH_W = stack_pkg::DEPTH_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         op,
    input  logic               inc,
    input  logic               dec,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic [1:0]         err
);
    import stack_pkg::*;

    logic [DEPTH_W-1:0] depth_reg;
    logic               below_two;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_reg <= '0;
        end else if (inc) begin
            depth_reg <= depth_reg + DEPTH_W'(1);
        end else if (dec) begin
            depth_reg <= depth_reg - DEPTH_W'(1);
        end
    end

    assign depth     = depth_reg;
    assign full      = (depth_reg == DEPTH_W'(DEPTH));
    assign empty     = (depth_reg == '0);
    assign below_two = (depth_reg < DEPTH_W'(2));

    always_comb begin
        err = ERR_OK;
        case (op)
            OP_NOP:           err = ERR_OK;
            OP_PUSH, OP_DUP:  err = full ? ERR_OVF : ERR_OK;
            // OVER needs a second operand; a missing operand outranks a full stack.
            OP_OVER: begin
                if (below_two)  err = ERR_UNF;
                else if (full)  err = ERR_OVF;
            end
            OP_POP, OP_DROP:  err = empty ? ERR_UNF : ERR_OK;
            OP_SWAP:          err = below_two ? ERR_UNF : ERR_OK;
            default:          err = ERR_ILL;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
// Command-level controller for the DEPTH x DW register stack.
// Ports:
//   clk, async_reset_n        : clock, asynchronous active-low reset
//   bus (slave)               : command in / response out handshakes
//   st_push/pop/write/read    : stack strobes, registered, one ISSUE cycle
//   st_reg0_in, st_reg1_in    : data for stack entries 0 and 1
//   st_reg1_overwrite         : load entry 1 in place (SWAP)
//   st_reg0_out, st_reg1_out  : current stack entries 0 and 1
//   depth, full, empty        : entry count and its limits
//   ovf_sticky, unf_sticky    : sticky error flags, cleared by clr_flags
// Flow: IDLE -> ISSUE -> SETTLE -> RESP (illegal commands skip SETTLE).
// -----------------------------------------------------------------------------
module stack_sequencer #(
    parameter int DEPTH   = stack_pkg::DEPTH,
    parameter int DW      = stack_pkg::DW,
    parameter int DEPTH_W = stack_pkg::DEPTH_W
) (
    input  logic               clk,
    input  logic               async_reset_n,
    stack_sequencer_if.slave   bus,
    output logic               st_push,
    output logic               st_pop,
    output logic               st_write,
    output logic               st_read,
    output logic [DW-1:0]      st_reg0_in,
    output logic [DW-1:0]      st_reg1_in,
    output logic               st_reg1_overwrite,
    input  logic [DW-1:0]      st_reg0_out,
    input  logic [DW-1:0]      st_reg1_out,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               empty,
    output logic               ovf_sticky,
    output logic               unf_sticky,
    input  logic               clr_flags
);
    import stack_pkg::*;

    state_t        state_reg;
    logic [2:0]    op_reg;
    logic [1:0]    err_reg;
    logic [1:0]    chk_err;
    logic [1:0]    rsp_err_reg;
    logic [DW-1:0] rsp_data_reg;
    logic          rsp_valid_reg;
    logic          push_reg, pop_reg, write_reg, read_reg, ovw_reg;
    logic [DW-1:0] reg0_in_reg, reg1_in_reg;
    logic          ovf_reg, unf_reg;
    logic          issue_ok;
    logic          depth_inc, depth_dec;

    // The check runs on the incoming opcode at acceptance. Depth cannot move
    // between acceptance and the end of ISSUE, so the verdict is the same as
    // checking in ISSUE, and it lets the strobes come straight from flops.
    stack_depth_tracker #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst_n (async_reset_n),
        .op    (bus.cmd_op),
        .inc   (depth_inc),
        .dec   (depth_dec),
        .depth (depth),
        .full  (full),
        .empty (empty),
        .err   (chk_err)
    );

    assign issue_ok  = (state_reg == S_ISSUE) && (err_reg == ERR_OK);
    assign depth_inc = issue_ok && is_grow(op_reg);
    assign depth_dec = issue_ok && is_shrink(op_reg);

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_reg     <= S_IDLE;
            op_reg        <= OP_NOP;
            err_reg       <= ERR_OK;
            rsp_err_reg   <= ERR_OK;
            rsp_data_reg  <= '0;
            rsp_valid_reg <= 1'b0;
            push_reg      <= 1'b0;
            pop_reg       <= 1'b0;
            write_reg     <= 1'b0;
            read_reg      <= 1'b0;
            ovw_reg       <= 1'b0;
            reg0_in_reg   <= '0;
            reg1_in_reg   <= '0;
        end else begin
            // Strobes live for exactly one cycle: whatever IDLE loads is
            // cleared again at the edge that ends ISSUE.
            push_reg    <= 1'b0;
            pop_reg     <= 1'b0;
            write_reg   <= 1'b0;
            read_reg    <= 1'b0;
            ovw_reg     <= 1'b0;
            reg0_in_reg <= '0;
            reg1_in_reg <= '0;

            case (state_reg)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op_reg    <= bus.cmd_op;
                        err_reg   <= chk_err;
                        state_reg <= S_ISSUE;
                        if (chk_err == ERR_OK) begin
                            case (bus.cmd_op)
                                OP_PUSH: begin
                                    write_reg   <= 1'b1;
                                    push_reg    <= 1'b1;
                                    reg0_in_reg <= bus.cmd_data;
                                end
                                OP_DUP: begin
                                    write_reg   <= 1'b1;
                                    push_reg    <= 1'b1;
                                    reg0_in_reg <= st_reg0_out;
                                end
                                OP_OVER: begin
                                    write_reg   <= 1'b1;
                                    push_reg    <= 1'b1;
                                    reg0_in_reg <= st_reg1_out;
                                end
                                OP_POP, OP_DROP: begin
                                    read_reg <= 1'b1;
                                    pop_reg  <= 1'b1;
                                end
                                OP_SWAP: begin
                                    write_reg   <= 1'b1;
                                    ovw_reg     <= 1'b1;
                                    reg0_in_reg <= st_reg1_out;
                                    reg1_in_reg <= st_reg0_out;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_ISSUE: begin
                    rsp_err_reg <= err_reg;
                    if (err_reg != ERR_OK) begin
                        rsp_data_reg  <= empty ? '0 : st_reg0_out;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= S_RESP;
                    end else begin
                        // POP reports the entry it removes, which is only
                        // visible before the stack shifts at this edge.
                        if (op_reg == OP_POP) begin
                            rsp_data_reg <= st_reg0_out;
                        end
                        state_reg <= S_SETTLE;
                    end
                end

                S_SETTLE: begin
                    if (op_reg != OP_POP) begin
                        rsp_data_reg <= st_reg0_out;
                    end
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= S_RESP;
                end

                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // A new error in the same cycle as clr_flags keeps the flag set.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if ((state_reg == S_ISSUE) && (err_reg == ERR_OVF)) ovf_reg <= 1'b1;
            else if (clr_flags)                                 ovf_reg <= 1'b0;
            if ((state_reg == S_ISSUE) && (err_reg == ERR_UNF)) unf_reg <= 1'b1;
            else if (clr_flags)                                 unf_reg <= 1'b0;
        end
    end

    assign bus.cmd_ready     = (state_reg == S_IDLE);
    assign bus.rsp_valid     = rsp_valid_reg;
    assign bus.rsp_data      = rsp_data_reg;
    assign bus.rsp_err       = rsp_err_reg;
    assign st_push           = push_reg;
    assign st_pop            = pop_reg;
    assign st_write          = write_reg;
    assign st_read           = read_reg;
    assign st_reg1_overwrite = ovw_reg;
    assign st_reg0_in        = reg0_in_reg;
    assign st_reg1_in        = reg1_in_reg;
    assign ovf_sticky        = ovf_reg;
    assign unf_sticky        = unf_reg;

endmodule

// File: tb/tb_stack_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stack_sequencer
// Drives commands into stack_sequencer, emulates the register stack it
// controls, and checks every response against a queue-based stack model.
// -----------------------------------------------------------------------------
module tb_stack_sequencer;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        async_reset_n = 1'b0;
    logic        st_push, st_pop, st_write, st_read, st_reg1_overwrite;
    logic [15:0] st_reg0_in, st_reg1_in, st_reg0_out, st_reg1_out;
    logic [7:0]  depth;
    logic        full, empty, ovf_sticky, unf_sticky;
    logic        clr_flags;

    stack_sequencer_if bus ();

    stack_sequencer dut (
        .clk               (clk),
        .async_reset_n     (async_reset_n),
        .bus               (bus.slave),
        .st_push           (st_push),
        .st_pop            (st_pop),
        .st_write          (st_write),
        .st_read           (st_read),
        .st_reg0_in        (st_reg0_in),
        .st_reg1_in        (st_reg1_in),
        .st_reg1_overwrite (st_reg1_overwrite),
        .st_reg0_out       (st_reg0_out),
        .st_reg1_out       (st_reg1_out),
        .depth             (depth),
        .full              (full),
        .empty             (empty),
        .ovf_sticky        (ovf_sticky),
        .unf_sticky        (unf_sticky),
        .clr_flags         (clr_flags)
    );

    always #5 clk = ~clk;

    // ---------------- emulated register stack (reacts to the strobes) -------
    logic [15:0] smem [0:127];
    int          scnt;

    assign st_reg0_out = (scnt > 0) ? smem[0] : 16'h0000;
    assign st_reg1_out = (scnt > 1) ? smem[1] : 16'h0000;

    always @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            scnt <= 0;
        end else if (st_push) begin
            for (int i = 127; i > 0; i--) smem[i] <= smem[i-1];
            smem[0] <= st_reg0_in;
            scnt    <= scnt + 1;
        end else if (st_pop) begin
            for (int i = 0; i < 127; i++) smem[i] <= smem[i+1];
            scnt <= scnt - 1;
        end else if (st_write) begin
            smem[0] <= st_reg0_in;
            if (st_reg1_overwrite) smem[1] <= st_reg1_in;
        end
    end

    // ---------------- counters and comparison ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [15:0] data;
        logic [1:0]  err;
        int          strobes;
        logic [2:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mq[$];          // mq[0] is the top of stack
    logic        m_ovf = 1'b0;
    logic        m_unf = 1'b0;

    function automatic logic [15:0] m_top();
        return (mq.size() > 0) ? mq[0] : 16'h0000;
    endfunction

    function automatic exp_t model_step(input logic [2:0] op, input logic [15:0] d);
        exp_t        e;
        logic [15:0] tmp;
        logic [15:0] top0;
        top0      = m_top();
        e.op      = op;
        e.err     = ERR_OK;
        e.strobes = 1;
        e.data    = 16'h0000;
        case (op)
            OP_PUSH: if (mq.size() == DEPTH) e.err = ERR_OVF; else mq.push_front(d);
            OP_DUP:  if (mq.size() == DEPTH) e.err = ERR_OVF; else mq.push_front(top0);
            OP_OVER: begin
                if (mq.size() < 2)           e.err = ERR_UNF;
                else if (mq.size() == DEPTH) e.err = ERR_OVF;
                else                         mq.push_front(mq[1]);
            end
            OP_POP:  if (mq.size() == 0) e.err = ERR_UNF; else e.data = mq.pop_front();
            OP_DROP: if (mq.size() == 0) e.err = ERR_UNF; else void'(mq.pop_front());
            OP_SWAP: begin
                if (mq.size() < 2) e.err = ERR_UNF;
                else begin
                    tmp   = mq[0];
                    mq[0] = mq[1];
                    mq[1] = tmp;
                end
            end
            OP_NOP:  e.strobes = 0;
            default: e.err = ERR_ILL;
        endcase
        if (e.err != ERR_OK) begin
            e.strobes = 0;
            e.data    = top0;
            if (e.err == ERR_OVF) m_ovf = 1'b1;
            if (e.err == ERR_UNF) m_unf = 1'b1;
        end else if (op != OP_POP) begin
            e.data = m_top();
        end
        return e;
    endfunction

    // ---------------- response-ready driver ----------------
    int ready_mode = 0;          // 0 high, 1 low, 2 random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.rsp_ready = 1'b1;
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    int   strobe_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!async_reset_n) begin
            strobe_cnt = 0;
        end else begin
            if (st_push || st_pop || st_write || st_read) strobe_cnt++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: actual data=%0h err=%0d required no response",
                             bus.rsp_data, bus.rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("rsp op=%0d data=%04h err=%0d (exp %04h/%0d)",
                             mon_e.op, bus.rsp_data, bus.rsp_err, mon_e.data, mon_e.err);
                    chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
                    chk("strobe_cycles", 32'(strobe_cnt), 32'(mon_e.strobes));
                end
                strobe_cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] op, input logic [15:0] d);
        int guard = 0;
        while (!bus.cmd_ready && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: actual cmd_ready=0 required 1 within 500 cycles");
        end
        exp_q.push_back(model_step(op, d));
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (!(bus.cmd_ready && exp_q.size() == 0) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 500) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: actual pending=%0d required 0 within 500 cycles", exp_q.size());
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, 32'(depth), 32'(mq.size()));
        chk({tag, "_full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, "_empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, "_ovf_sticky"}, 32'(ovf_sticky), 32'(m_ovf));
        chk({tag, "_unf_sticky"}, 32'(unf_sticky), 32'(m_unf));
        chk({tag, "_top"}, 32'(st_reg0_out), 32'(m_top()));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_strobes"}, 32'({st_push, st_pop, st_write, st_read, st_reg1_overwrite}), 32'd0);
        chk({tag, "_reg_in"}, 32'({st_reg0_in, st_reg1_in}), 32'd0);
        chk({tag, "_depth"}, 32'(depth), 32'd0);
        chk({tag, "_full_empty"}, 32'({full, empty}), 32'b01);
        chk({tag, "_sticky"}, 32'({ovf_sticky, unf_sticky}), 32'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        async_reset_n = 1'b0;
        #2;
        model_reset();
        check_reset_vals(tag);
        @(posedge clk); #1;
        async_reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic clear_flags();
        wait_idle();
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          g;
        int          r;
        logic [2:0]  op;
        logic [15:0] held;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_data  = 16'h0000;
        clr_flags     = 1'b0;
        #12;
        check_reset_vals("por");
        @(posedge clk); #1;
        async_reset_n = 1'b1;
        @(posedge clk); #1;

        // basic push/push/pop
        issue(OP_PUSH, 16'h1234);
        issue(OP_PUSH, 16'hBEEF);
        issue(OP_POP, 16'h0000);
        wait_idle();
        check_state("basic");

        // drain to empty, then underflow and flag clear
        issue(OP_POP, 16'h0000);
        issue(OP_POP, 16'h0000);
        wait_idle();
        check_state("underflow");
        clear_flags();
        check_state("clr_unf");

        // fill to full, then overflow on PUSH and DUP
        for (int i = 0; i < 128; i++) issue(OP_PUSH, 16'(i));
        wait_idle();
        check_state("full");
        issue(OP_PUSH, 16'hFFFF);
        wait_idle();
        check_state("ovf_push");
        issue(OP_DUP, 16'h0000);
        wait_idle();
        check_state("ovf_dup");

        // SWAP / OVER / DROP on [0x0A, 0x0B]
        do_reset("rst2");
        issue(OP_PUSH, 16'h000B);
        issue(OP_PUSH, 16'h000A);
        issue(OP_SWAP, 16'h0000);
        wait_idle();
        check_state("swap");
        issue(OP_OVER, 16'h0000);
        wait_idle();
        check_state("over");
        issue(OP_DROP, 16'h0000);
        wait_idle();
        check_state("drop");

        // back-pressure on the response channel
        ready_mode = 1;
        @(posedge clk); #1;
        issue(OP_PUSH, 16'h5555);
        g = 0;
        while (!bus.rsp_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        chk("bp_rsp_valid_rise", 32'(bus.rsp_valid), 32'd1);
        held = bus.rsp_data;
        for (int i = 0; i < 10; i++) begin
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_data", 32'(bus.rsp_data), 32'h5555);
            chk("bp_rsp_stable", 32'(bus.rsp_data), 32'(held));
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            @(posedge clk); #1;
        end
        ready_mode = 0;
        wait_idle();
        issue(3'd7, 16'h0000);
        wait_idle();
        check_state("illegal");

        // reset during SETTLE of a PUSH
        issue(OP_PUSH, 16'h4242);
        @(posedge clk); #2;
        async_reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("midrst");
        @(posedge clk); #1;
        async_reset_n = 1'b1;
        @(posedge clk); #1;
        check_state("after_midrst");
        issue(OP_PUSH, 16'h7777);
        wait_idle();
        check_state("post_midrst_cmd");

        // randomized traffic with random response back-pressure
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      op = OP_PUSH;
            else if (r < 4) op = OP_DUP;
            else if (r < 5) op = OP_OVER;
            else if (r < 6) op = OP_POP;
            else if (r < 7) op = OP_DROP;
            else if (r < 8) op = OP_SWAP;
            else if (r < 9) op = OP_NOP;
            else            op = 3'd7;
            if (mq.size() > 100 && r < 5) op = OP_DROP;
            issue(op, 16'($urandom));
            if (n % 25 == 24) begin
                wait_idle();
                check_state("rand");
                if ($urandom_range(0, 1) == 1) clear_flags();
            end
        end
        ready_mode = 0;
        wait_idle();
        check_state("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: actual simulation still running required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
